ssd_scan_reader: RTL

Receive-side counterpart of the seven-segment driver path. It monitors a multiplexed 4-digit seven-segment bus (one-hot digit enable plus segments a–g and dp) and waits until each pattern has been stable for a programmable number of cycles. It then decodes the pattern back to a hex nibble and assembles all four digits into a 16-bit word. Intended use: display loop-back checking on the board and self-checking of the display path in simulation.

---
 rtl/ssd_pkg.sv | 26 ++
 rtl/ssd_pattern_decode.sv | 24 ++
 rtl/ssd_scan_reader.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// Shared seven-segment definitions: digit geometry, hex segment codes,
// scan-reader FSM encoding and snapshot layout. Used by driver and reader.
package ssd_pkg;

  localparam int SEG_W = 7;
  localparam int DIG_N = 4;

  // Segment codes for hex digits 0..F, bit order gfedcba (bit0 = a).
  localparam logic [SEG_W-1:0] SEG_CODE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic {
    TRACK = 1'b0,
    HOLD  = 1'b1
  } scan_state_e;

  // One registered sample of the display bus, polarity already normalised.
  typedef struct packed {
    logic [DIG_N-1:0] dig;
    logic             dp;
    logic [SEG_W-1:0] seg;
  } snap_t;

endpackage

// File: rtl/ssd_pattern_decode.sv
// Combinational seven-segment pattern to hex nibble decoder.
// hit is low for any pattern that is not one of the 16 hex glyphs.
module ssd_pattern_decode
  import ssd_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  output logic [3:0]       nibble,
  output logic             hit
);

  // Search the code table for an exact match.
  always_comb begin
    // NOTE: defaults assigned first so every path drives both outputs (no latch).
    nibble = '0;
    hit    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == SEG_CODE[i]) begin
        nibble = 4'(i);
        hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ssd_scan_reader.sv
// Seven-segment scan reader: samples a multiplexed 4-digit display bus,
// accepts each pattern once it has been stable for STABLE_CYCLES edges,
// decodes it and assembles a 16-bit word plus per-digit dp flags.
module ssd_scan_reader
  import ssd_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SEG_W-1:0]     seg_in,
  input  logic                 dp_in,
  input  logic [DIG_N-1:0]     dig_en,
  output logic [4*DIG_N-1:0]   value,
  output logic [DIG_N-1:0]     dp_out,
  output logic                 valid,
  output logic                 decode_err,
  output logic [DIG_N-1:0]     digit_seen
);

  localparam logic [7:0] ACCEPT_CNT = 8'(STABLE_CYCLES - 1);

  snap_t               snap_in;
  snap_t               snap;
  logic                changed;
  logic [7:0]          stable_cnt;
  scan_state_e         state;
  scan_state_e         state_d;
  logic                accept;
  logic [3:0]          nibble;
  logic                hit;
  logic                dig_any;
  logic                dig_onehot;
  logic [1:0]          dig_idx;
  logic                do_write;
  logic                err_d;
  logic                word_done;
  logic [DIG_N-1:0]    seen_d;
  logic [4*DIG_N-1:0]  shadow_val;
  logic [4*DIG_N-1:0]  shadow_val_d;
  logic [DIG_N-1:0]    shadow_dp;
  logic [DIG_N-1:0]    shadow_dp_d;

  // Segment/dp polarity is normalised on the way into the snapshot.
  assign snap_in = '{dig: dig_en,
                     dp:  dp_in ^ SEG_ACTIVE_LOW,
                     seg: seg_in ^ {SEG_W{SEG_ACTIVE_LOW}}};
  assign changed = (snap_in != snap);

  // Snapshot register and saturating stability counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap       <= '0;
      stable_cnt <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      snap <= snap_in;
      if (changed)
        stable_cnt <= '0;
      else if (stable_cnt != 8'hFF)
        stable_cnt <= stable_cnt + 8'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= TRACK;
    else     state <= state_d;
  end

  // Next state: one accept per stable period; any change rearms tracking.
  always_comb begin
    state_d = state;
    accept  = 1'b0;
    if (state == TRACK && stable_cnt == ACCEPT_CNT) begin
      accept  = 1'b1;
      state_d = HOLD;
    end
    if (changed) state_d = TRACK;
  end

  ssd_pattern_decode u_decode (
    .pattern (snap.seg),
    .nibble  (nibble),
    .hit     (hit)
  );

  // Classify the digit enable and find the selected slot.
  always_comb begin
    dig_any    = |snap.dig;
    dig_onehot = dig_any && ((snap.dig & (snap.dig - 4'd1)) == '0);
    dig_idx    = '0;
    for (int i = 0; i < DIG_N; i++) begin
      if (snap.dig[i]) dig_idx = 2'(i);
    end
  end

  // Work out the shadow write, error pulse and word completion for this edge.
  always_comb begin
    do_write     = accept && dig_onehot && hit;
    err_d        = accept && dig_any && !(dig_onehot && hit);
    shadow_val_d = shadow_val;
    shadow_dp_d  = shadow_dp;
    seen_d       = digit_seen;
    if (do_write) begin
      shadow_val_d[{dig_idx, 2'b00} +: 4] = nibble;
      shadow_dp_d[dig_idx]                = snap.dp;
      seen_d                              = digit_seen | snap.dig;
    end
    word_done = do_write && (&seen_d);
  end

  // Shadow slots, output word and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: shadow slots are reset too, so no partial word outlives rst.
      shadow_val <= '0;
      shadow_dp  <= '0;
      value      <= '0;
      dp_out     <= '0;
      valid      <= 1'b0;
      decode_err <= 1'b0;
      digit_seen <= '0;
    end else begin
      shadow_val <= shadow_val_d;
      shadow_dp  <= shadow_dp_d;
      valid      <= word_done;
      decode_err <= err_d;
      if (word_done) begin
        value      <= shadow_val_d;
        dp_out     <= shadow_dp_d;
        digit_seen <= '0;
      end else begin
        digit_seen <= seen_d;
      end
    end
  end

endmodule
